// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - signed product to sign + BCD digits via iterative double dabble
module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [WIDTH/2-1:0]    Aval,
    input  logic [WIDTH/2-1:0]    Bval,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Sign,
    output logic [4*DIGITS-1:0]   BCD
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [WIDTH-1:0]      product;
    logic [WIDTH-1:0]      mag;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   scratch_adj;
    logic [CW-1:0]         count;
    logic                  sign_int;

    assign product = {Aval, Bval};
    assign Busy    = (state != S_IDLE);

    // Add-3 correction on every digit that would overflow past 9 after the next doubling
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE waits for Start, SHIFT runs WIDTH iterations, DONE publishes
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start) state_nxt = S_SHIFT;
            S_SHIFT: if (count == CW'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture magnitude, shift through scratch, publish result on DONE only
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mag      <= '0;
            scratch  <= '0;
            count    <= '0;
            sign_int <= 1'b0;
            Done     <= 1'b0;
            Sign     <= 1'b0;
            BCD      <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        sign_int <= product[WIDTH-1];
                        // Negating 0x8000 yields 0x8000, which reads correctly as unsigned 32768
                        mag      <= product[WIDTH-1] ? (~product + WIDTH'(1)) : product;
                        scratch  <= '0;
                        count    <= CW'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    {scratch, mag} <= {scratch_adj, mag} << 1;
                    count          <= count - CW'(1);
                end
                S_DONE: begin
                    BCD  <= scratch;
                    Sign <= sign_int;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// tb/tb_product_bcd_converter.sv - directed self-checking bench for product_bcd_converter
module tb_product_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  aval;
    logic [7:0]  bval;
    logic        busy;
    logic        done;
    logic        sign;
    logic [19:0] bcd;

    int total  = 0;
    int passed = 0;

    product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .Start   (start),
        .Aval    (aval),
        .Bval    (bval),
        .Busy    (busy),
        .Done    (done),
        .Sign    (sign),
        .BCD     (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            passed++;
        end
    endtask

    // One full conversion: latency, busy length, result and single-cycle Done
    task automatic convert(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic exp_sign, input logic [19:0] exp_bcd);
        int n;
        int busy_n;
        @(negedge clk);
        aval  = a;
        bval  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        busy_n = busy ? 1 : 0;
        n      = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_n++;
        end
        check({tag, "_latency"}, n, 17);
        check({tag, "_busy_cycles"}, busy_n, 17);
        check({tag, "_sign"}, sign, exp_sign);
        check({tag, "_bcd"}, bcd, exp_bcd);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_bcd_hold"}, bcd, exp_bcd);
    endtask

    initial begin
        int dn;
        int d_at [2];
        logic [19:0] d_bcd [2];
        logic        d_sign [2];

        rst_n = 1'b0;
        start = 1'b0;
        aval  = 8'h00;
        bval  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sign", sign, 1'b0);
        check("rst_bcd", bcd, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload a nonzero result so the asynchronous clear is observable
        convert("m100", 8'hFF, 8'h9C, 1'b1, 20'h00100);

        // Asynchronous reset mid-SHIFT
        @(negedge clk);
        aval  = 8'h12;
        bval  = 8'h34;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_bcd", bcd, 20'h0);
        check("arst_sign", sign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("arst_no_done", dn, 0);

        convert("p7", 8'h00, 8'h07, 1'b0, 20'h00007);
        convert("m32768", 8'h80, 8'h00, 1'b1, 20'h32768);
        convert("p32767", 8'h7F, 8'hFF, 1'b0, 20'h32767);
        convert("p16384", 8'h40, 8'h00, 1'b0, 20'h16384);
        convert("m1", 8'hFF, 8'hFF, 1'b1, 20'h00001);
        convert("p1234", 8'h04, 8'hD2, 1'b0, 20'h01234);

        // Start while busy is ignored; inputs changed mid-conversion are not re-sampled
        @(negedge clk);
        aval  = 8'h00;
        bval  = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        aval  = 8'hFF;
        bval  = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dn++;
                check("ign_sign", sign, 1'b0);
                check("ign_bcd", bcd, 20'h00001);
            end
        end
        check("ign_done_count", dn, 1);

        // Start held high: back-to-back conversions every 18 cycles
        @(negedge clk);
        aval  = 8'h00;
        bval  = 8'h00;
        start = 1'b1;
        dn    = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (dn < 2) begin
                    d_at[dn]   = e;
                    d_bcd[dn]  = bcd;
                    d_sign[dn] = sign;
                end
                dn++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", dn, 2);
        if (dn >= 2) begin
            check("b2b_first_at", d_at[0], 17);
            check("b2b_second_at", d_at[1], 35);
            check("b2b_bcd0", d_bcd[0], 20'h0);
            check("b2b_bcd1", d_bcd[1], 20'h0);
            check("b2b_sign0", d_sign[0], 1'b0);
            check("b2b_sign1", d_sign[1], 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
- Downstream consumer of the 8x8 signed multiplier result.
- Takes the 16-bit two's-complement product {Aval, Bval} and converts it iteratively (shift-add-3 / double dabble) into sign + 5 decimal BCD digits for the decimal display path.
- One conversion per Start request; Done/Busy handshake.

Parameters:
- WIDTH, 16, bit width of the signed input product.
- DIGITS, 5, number of BCD output digits. Must hold 2^(WIDTH-1), i.e. 32768 for WIDTH=16.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  conversion request, sampled on Clk only in IDLE.
- Aval  input  WIDTH/2  upper half of the product (multiplier register A).
- Bval  input  WIDTH/2  lower half of the product (multiplier register B).
- Busy  output  1  high while state != IDLE.
- Done  output  1  one-cycle pulse: new result valid.
- Sign  output  1  1 = result negative.
- BCD  output  4*DIGITS  magnitude digits, most significant digit at [4*DIGITS-1 -: 4].

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - State = IDLE.
  - Busy=0, Done=0, Sign=0, BCD=0.
  - Internal magnitude, scratch and counter registers = 0.
- Reset asserted mid-conversion aborts immediately; no partial result is ever presented.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Start=1 at edge k: capture P = {Aval, Bval} and Sign_int = P[WIDTH-1].
  - Mag = two's-complement negate of P (WIDTH bits, unsigned) if negative, else P.
  - Clear scratch BCD; counter = WIDTH; go to SHIFT.
  - Start=0: stay in IDLE.
- SHIFT: one iteration per edge, k+1 .. k+WIDTH.
  - Every scratch digit >= 5 gets +3, all digits in parallel, combinationally.
  - Then {scratch, Mag} shifts left 1; Mag LSB fills with 0.
  - Counter decrements each iteration. After the iteration where the counter goes 1 -> 0, go to DONE.
- DONE, edge k+WIDTH+1:
  - BCD <= scratch; Sign <= Sign_int; Done <= 1; go to IDLE.
- Latency: Done and the new BCD/Sign are visible in the cycle after edge k+17 (WIDTH=16), i.e. 17 cycles after Start is sampled.
- Busy is combinational from state: high after edge k through edge k+17, low in the cycle Done is high.
- Done is high for exactly one cycle. BCD/Sign hold their value until the next DONE or reset.
- Start while Busy=1 is ignored; no queuing.
- Start held high continuously gives back-to-back conversions, one accepted every WIDTH+2 = 18 cycles. The next Start is accepted at the edge after the Done cycle.
- Aval/Bval changes after edge k do not affect the conversion in progress (captured once).
- Width/corner rules:
  - Most negative input 0x8000: negate gives unsigned 0x8000 = 32768, Sign=1.
  - Zero: Sign=0, BCD=0 (no negative zero).
  - Scratch is 4*DIGITS bits; a +3 correction never overflows a digit, since pre-shift digits are <= 9.

Test Plan:
- Reset_n=0 mid-SHIFT (e.g. 5 cycles after Start with {0x12,0x34}) -> Busy=0, Done=0, BCD=0x00000, Sign=0 immediately (asynchronous); no Done pulse follows; the next Start converts normally.
- Aval=0x00, Bval=0x07, Start pulse -> after exactly 17 cycles Done=1 for one cycle, Sign=0, BCD=0x00007; Busy high for 17 cycles then low.
- Aval=0xFF, Bval=0x9C (-100) -> Sign=1, BCD=0x00100.
- Aval=0x80, Bval=0x00 (-32768) -> Sign=1, BCD=0x32768; Aval=0x7F, Bval=0xFF -> Sign=0, BCD=0x32767; Aval=0x40, Bval=0x00 (product of -128*-128) -> Sign=0, BCD=0x16384.
- Start pulsed again 3 cycles into a conversion of 0x0001, with Aval/Bval changed to 0xFFFF -> ignored; result Sign=0, BCD=0x00001; only one Done pulse.
- Start held high with input 0x0000 for 40 cycles -> Done pulses exactly at cycles 17 and 35 (18-cycle spacing); BCD=0x00000, Sign=0 both times.
